// File: rtl/typedef_pkg.sv
// Shared types for the dispatch credit controller: reservation-station class,
// controller state and the per-class demand helper.
package typedef_pkg;

  typedef enum logic [1:0] {
    RS_ALU  = 2'd0,
    RS_LS   = 2'd1,
    RS_BR   = 2'd2,
    RS_NONE = 2'd3
  } rs_class_t;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } ctrl_state_t;

  // Number of valid slots (0..2) of the renamed pair that target class cls.
  function automatic logic [1:0] class_demand(input logic [1:0] valid,
                                              input rs_class_t  cls_0,
                                              input rs_class_t  cls_1,
                                              input rs_class_t  cls);
    logic [1:0] d0;
    logic [1:0] d1;
    d0 = {1'b0, valid[0] && (cls_0 == cls)};
    d1 = {1'b0, valid[1] && (cls_1 == cls)};
    return d0 + d1;
  endfunction

endpackage

// File: rtl/dispatch_credit_ctrl_if.sv
// Rename-to-dispatch handshake: the renamed pair travels one way, the stall the other.
interface dispatch_credit_ctrl_if;
  import typedef_pkg::*;

  logic [1:0] rename_valid;
  rs_class_t  rename_class_0;
  rs_class_t  rename_class_1;
  logic       stall_dispatch;

  modport master (
    output rename_valid,
    output rename_class_0,
    output rename_class_1,
    input  stall_dispatch
  );

  modport slave (
    input  rename_valid,
    input  rename_class_0,
    input  rename_class_1,
    output stall_dispatch
  );

endinterface

// File: rtl/rs_credit_counter.sv
// Free-entry credit counter for one reservation station: consumes accepted
// demand, returns issue credits, reloads on flush and clamps at full.
module rs_credit_counter #(
  parameter int NUM_RS_ENTRIES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           demand,
  input  logic                 accept,
  input  logic                 issue,
  input  logic                 reload,
  output logic [CNT_WIDTH-1:0] free,
  output logic                 overflow
);

  localparam logic [CNT_WIDTH-1:0] FULL     = CNT_WIDTH'(NUM_RS_ENTRIES);
  localparam logic [CNT_WIDTH:0]   FULL_EXT = (CNT_WIDTH+1)'(NUM_RS_ENTRIES);

  logic [CNT_WIDTH:0] take;
  logic [CNT_WIDTH:0] sum;

  // One extra bit so an over-return is visible before clamping.
  always_comb begin
    take     = accept ? {{(CNT_WIDTH-1){1'b0}}, demand} : '0;
    sum      = {1'b0, free} - take + {{CNT_WIDTH{1'b0}}, issue};
    overflow = !reload && (sum > FULL_EXT);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free <= FULL;
    end else if (reload || overflow) begin
      free <= FULL;
    end else begin
      free <= sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dispatch_credit_ctrl.sv
// Dispatch credit controller: accepts a renamed pair all-or-nothing against the
// registered free counts of the ALU, LS and BR reservation stations.
module dispatch_credit_ctrl
  import typedef_pkg::*;
#(
  parameter int NUM_RS_ENTRIES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  dispatch_credit_ctrl_if.slave   rn,
  input  logic                    issue_alu_valid,
  input  logic                    issue_ls_valid,
  input  logic                    issue_branch_valid,
  output logic [CNT_WIDTH-1:0]    free_alu,
  output logic [CNT_WIDTH-1:0]    free_ls,
  output logic [CNT_WIDTH-1:0]    free_br,
  output logic                    credit_err
);

  ctrl_state_t state;
  ctrl_state_t state_nxt;

  logic [1:0] dem_alu;
  logic [1:0] dem_ls;
  logic [1:0] dem_br;
  logic       stall;
  logic       run;
  logic       ovf_alu;
  logic       ovf_ls;
  logic       ovf_br;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT:    state_nxt = ST_RUN;
      ST_RUN:     if (flush) state_nxt = ST_RECOVER;
      ST_RECOVER: state_nxt = flush ? ST_RECOVER : ST_RUN;
      default:    state_nxt = ST_INIT;
    endcase
  end

  assign dem_alu = class_demand(rn.rename_valid, rn.rename_class_0, rn.rename_class_1, RS_ALU);
  assign dem_ls  = class_demand(rn.rename_valid, rn.rename_class_0, rn.rename_class_1, RS_LS);
  assign dem_br  = class_demand(rn.rename_valid, rn.rename_class_0, rn.rename_class_1, RS_BR);

  assign run = (state == ST_RUN);

  // Stall compares against registered counts only; same-cycle issue returns
  // become usable on the following cycle.
  always_comb begin
    stall = !run || flush
         || (CNT_WIDTH'(dem_alu) > free_alu)
         || (CNT_WIDTH'(dem_ls)  > free_ls)
         || (CNT_WIDTH'(dem_br)  > free_br);
  end

  assign rn.stall_dispatch = stall;

  rs_credit_counter #(.NUM_RS_ENTRIES(NUM_RS_ENTRIES), .CNT_WIDTH(CNT_WIDTH)) u_alu (
    .clk      (clk),
    .rst      (rst),
    .demand   (dem_alu),
    .accept   (!stall),
    .issue    (issue_alu_valid && run),
    .reload   (flush),
    .free     (free_alu),
    .overflow (ovf_alu)
  );

  rs_credit_counter #(.NUM_RS_ENTRIES(NUM_RS_ENTRIES), .CNT_WIDTH(CNT_WIDTH)) u_ls (
    .clk      (clk),
    .rst      (rst),
    .demand   (dem_ls),
    .accept   (!stall),
    .issue    (issue_ls_valid && run),
    .reload   (flush),
    .free     (free_ls),
    .overflow (ovf_ls)
  );

  rs_credit_counter #(.NUM_RS_ENTRIES(NUM_RS_ENTRIES), .CNT_WIDTH(CNT_WIDTH)) u_br (
    .clk      (clk),
    .rst      (rst),
    .demand   (dem_br),
    .accept   (!stall),
    .issue    (issue_branch_valid && run),
    .reload   (flush),
    .free     (free_br),
    .overflow (ovf_br)
  );

  // Sticky until reset so software can observe a lost-credit event later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         credit_err <= 1'b0;
    else if (ovf_alu || ovf_ls || ovf_br) credit_err <= 1'b1;
  end

endmodule
